waveform_sequencer: RTL and testbench

// - Run-time controller for the BRAM waveform table: selects one of 2**SEL_W stored waveforms,

---
 rtl/waveform_sequencer.sv | 177 +++++++++++++++++
 tb/tb_waveform_sequencer.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/waveform_sequencer.sv
// Waveform sequencer: selects a stored waveform, paces BRAM reads with a clock divider, runs bursts or continuous.
// Latency: first read in the first RUN cycle; sample_valid follows each bram_en by BRAM_LAT cycles.
// Backpressure: none on the sample path; config is only accepted in IDLE (cfg_ready low while busy).
//
// Ports: clk/rst (sync, active-high); cfg_valid/cfg_ready/cfg_sel/cfg_div/cfg_burst config handshake;
// start/stop run control; bram_en/bram_addr/bram_dout BRAM read port; sample_out/sample_valid data out;
// busy/done status. Optional build macro WAVESEQ_PHASE_EN adds cfg_phase (run start address).
module waveform_sequencer #(
    parameter int ADDR_W   = 8,
    parameter int SEL_W    = 2,
    parameter int DATA_W   = 8,
    parameter int DIV_W    = 16,
    parameter int BURST_W  = 16,
    parameter int BRAM_LAT = 1,
    parameter int DIV_RST  = 100
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    cfg_valid,
    output logic                    cfg_ready,
    input  logic [SEL_W-1:0]        cfg_sel,
    input  logic [DIV_W-1:0]        cfg_div,
    input  logic [BURST_W-1:0]      cfg_burst,
`ifdef WAVESEQ_PHASE_EN
    input  logic [ADDR_W-1:0]       cfg_phase,
`endif
    input  logic                    start,
    input  logic                    stop,
    output logic                    bram_en,
    output logic [SEL_W+ADDR_W-1:0] bram_addr,
    input  logic [DATA_W-1:0]       bram_dout,
    output logic [DATA_W-1:0]       sample_out,
    output logic                    sample_valid,
    output logic                    busy,
    output logic                    done
);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN} state_t;

    state_t               state_q, state_n;
    logic [SEL_W-1:0]     sel_q;
    logic [DIV_W-1:0]     div_q;
    logic [BURST_W-1:0]   burst_q;
    logic [ADDR_W-1:0]    phase_q;
    logic [ADDR_W-1:0]    addr_q;
    logic [DIV_W-1:0]     divc_q;
    logic [BURST_W-1:0]   pcnt_q;
    logic [2:0]           dcnt_q;
    logic [BRAM_LAT-1:0]  vpipe_q;
    logic [DATA_W-1:0]    sample_q;

    logic                 cfg_fire;
    logic [ADDR_W-1:0]    start_addr;
    logic [DIV_W-1:0]     div_eff;
    logic                 tick;
    logic                 at_end;
    logic                 last_period;

    assign cfg_fire    = (state_q == S_IDLE) && cfg_valid;
    assign div_eff     = (div_q == '0) ? DIV_W'(1) : div_q;
    // Counter starts at 0 on entry, so the first read lands in the first RUN cycle.
    assign tick        = (divc_q == '0);
    // The period closes on the read just before the address wraps back to the start address.
    assign at_end      = (addr_q == phase_q - ADDR_W'(1));
    assign last_period = (burst_q != '0) && (pcnt_q == burst_q - BURST_W'(1));

`ifdef WAVESEQ_PHASE_EN
    // A config written in the same cycle as start must already steer the start address.
    assign start_addr = cfg_fire ? cfg_phase : phase_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            phase_q <= '0;
        end else if (cfg_fire) begin
            phase_q <= cfg_phase;
        end
    end
`else
    assign phase_q    = '0;
    assign start_addr = '0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_n;
        end
    end

    always_comb begin
        state_n = state_q;
        bram_en = 1'b0;
        done    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_n = S_RUN;
                end
            end
            S_RUN: begin
                if (stop) begin
                    // Stop wins, but a period-closing read already due this cycle still goes out.
                    bram_en = tick && at_end;
                    state_n = S_DRAIN;
                end else if (tick) begin
                    bram_en = 1'b1;
                    if (at_end && last_period) begin
                        state_n = S_DRAIN;
                    end
                end
            end
            S_DRAIN: begin
                if (dcnt_q == 3'(BRAM_LAT - 1)) begin
                    done    = 1'b1;
                    state_n = S_IDLE;
                end
            end
            default: state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sel_q    <= '0;
            div_q    <= DIV_W'(DIV_RST);
            burst_q  <= '0;
            addr_q   <= '0;
            divc_q   <= '0;
            pcnt_q   <= '0;
            dcnt_q   <= '0;
            vpipe_q  <= '0;
            sample_q <= '0;
        end else begin
            if (cfg_fire) begin
                sel_q   <= cfg_sel;
                div_q   <= cfg_div;
                burst_q <= cfg_burst;
            end

            if (state_q == S_IDLE) begin
                divc_q <= '0;
                pcnt_q <= '0;
                if (start) begin
                    addr_q <= start_addr;
                end
            end else if (state_q == S_RUN) begin
                divc_q <= (divc_q == div_eff - DIV_W'(1)) ? '0 : divc_q + DIV_W'(1);
                if (bram_en) begin
                    addr_q <= addr_q + ADDR_W'(1);
                    if (at_end) begin
                        pcnt_q <= pcnt_q + BURST_W'(1);
                    end
                end
            end

            dcnt_q <= (state_q == S_DRAIN) ? dcnt_q + 3'd1 : 3'd0;

            // Read-enable delay line marks when bram_dout carries the requested sample.
            vpipe_q[0] <= bram_en;
            for (int i = 1; i < BRAM_LAT; i++) begin
                vpipe_q[i] <= vpipe_q[i-1];
            end

            if (sample_valid) begin
                sample_q <= bram_dout;
            end
        end
    end

    assign cfg_ready    = (state_q == S_IDLE);
    assign busy         = (state_q != S_IDLE);
    assign bram_addr    = {sel_q, addr_q};
    assign sample_valid = vpipe_q[BRAM_LAT-1];
    assign sample_out   = sample_q;

endmodule

// File: tb/tb_waveform_sequencer.sv
// Bench for waveform_sequencer: scoreboard of expected reads, samples and done pulses.
// Expected events carry their absolute cycle; a negedge monitor pops and compares.
// Stimulus is a mix of directed runs and $urandom-chosen runs.
module tb_waveform_sequencer;

    localparam int LAT = 2;

    typedef struct {
        int cyc;
        int val;
    } ev_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cfg_valid = 1'b0;
    logic        cfg_ready;
    logic [1:0]  cfg_sel = '0;
    logic [15:0] cfg_div = '0;
    logic [15:0] cfg_burst = '0;
`ifdef WAVESEQ_PHASE_EN
    logic [7:0]  cfg_phase = '0;
`endif
    logic        start = 1'b0;
    logic        stop = 1'b0;
    logic        bram_en;
    logic [9:0]  bram_addr;
    logic [7:0]  bram_dout;
    logic [7:0]  sample_out;
    logic        sample_valid;
    logic        busy;
    logic        done;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    ev_t rdq[$];
    ev_t smq[$];
    int  dnq[$];

    // Shadow of the configuration the DUT should currently hold.
    int m_sel = 0, m_div = 100, m_burst = 0, m_phase = 0;

    waveform_sequencer #(.BRAM_LAT(LAT)) dut (
        .clk(clk), .rst(rst),
        .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
        .cfg_sel(cfg_sel), .cfg_div(cfg_div), .cfg_burst(cfg_burst),
`ifdef WAVESEQ_PHASE_EN
        .cfg_phase(cfg_phase),
`endif
        .start(start), .stop(stop),
        .bram_en(bram_en), .bram_addr(bram_addr), .bram_dout(bram_dout),
        .sample_out(sample_out), .sample_valid(sample_valid),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [7:0] romf(input int a);
        return 8'((a * 37 + (a >> 3) + 11) & 255);
    endfunction

    // BRAM model: data appears LAT cycles after the address is presented.
    logic [7:0] dpipe [LAT];
    always @(posedge clk) begin
        dpipe[0] <= romf(int'(bram_addr));
        for (int i = 1; i < LAT; i++) dpipe[i] <= dpipe[i-1];
    end
    assign bram_dout = dpipe[LAT-1];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor
    bit       pend = 1'b0;
    int       pend_val = 0;
    always @(negedge clk) begin
        ev_t e;
        if (bram_en) begin
            if (rdq.size() == 0) chk("unexpected_bram_en", 1, 0);
            else begin
                e = rdq.pop_front();
                chk("read_cycle", cyc, e.cyc);
                chk("read_addr", 32'(bram_addr), e.val);
            end
        end
        if (pend) begin
            chk("sample_out", 32'(sample_out), pend_val);
            pend = 1'b0;
        end
        if (sample_valid) begin
            if (smq.size() == 0) chk("unexpected_sample_valid", 1, 0);
            else begin
                e = smq.pop_front();
                chk("sample_cycle", cyc, e.cyc);
                if (!rst) begin
                    pend = 1'b1;
                    pend_val = e.val;
                end
            end
        end
        if (done) begin
            if (dnq.size() == 0) chk("unexpected_done", 1, 0);
            else chk("done_cycle", cyc, dnq.pop_front());
        end
    end

    task automatic go_cyc(input int t);
        while (cyc < t) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Reference: reads are paced deff apart from C0; each 256 reads is a period.
    task automatic gen(input int c0, input int deff, input int burst, input int phase,
                       input int sel, input int s, input int r,
                       output int done_c, output bit stopped);
        int j = 0;
        int last = c0 - 1;
        int c;
        ev_t e;
        stopped = 1'b0;
        forever begin
            if (burst != 0 && j == burst * 256) break;
            c = c0 + j * deff;
            if (r >= 0 && c > r) break;
            if (s >= 0 && c >= s) begin
                stopped = 1'b1;
                if (!(c == s && ((j + 1) % 256) == 0)) break;
            end
            e.cyc = c;
            e.val = sel * 256 + ((phase + j) % 256);
            rdq.push_back(e);
            if (r < 0 || c + LAT <= r) begin
                e.cyc = c + LAT;
                e.val = int'(romf(e.val));
                smq.push_back(e);
            end
            last = c;
            j++;
            if (stopped) break;
        end
        done_c = (r >= 0) ? -1 : ((stopped ? s + 1 : last + 1) + LAT - 1);
        if (done_c >= 0) dnq.push_back(done_c);
    endtask

    task automatic run_case(input int sel, input int div, input int burst, input int phase,
                            input int stop_off, input bit with_cfg, input bit same_cyc,
                            input bit mid_cfg, input int rst_off);
        int c0, s, r, dc, deff;
        bit stp;
        if (with_cfg) begin
            cfg_sel = 2'(sel); cfg_div = 16'(div); cfg_burst = 16'(burst);
`ifdef WAVESEQ_PHASE_EN
            cfg_phase = 8'(phase);
            m_phase = phase;
`endif
            m_sel = sel; m_div = div; m_burst = burst;
            cfg_valid = 1'b1;
            chk("cfg_ready_idle", 32'(cfg_ready), 1);
            if (!same_cyc) begin
                go_cyc(cyc + 1);
                cfg_valid = 1'b0;
            end
        end
        start = 1'b1;
        c0 = cyc + 1;
        deff = (m_div == 0) ? 1 : m_div;
        s = (stop_off >= 0) ? c0 + stop_off : -1;
        r = (rst_off >= 0) ? c0 + rst_off : -1;
        gen(c0, deff, m_burst, m_phase, m_sel, s, r, dc, stp);
        go_cyc(c0);
        start = 1'b0;
        cfg_valid = 1'b0;
        chk("busy_run", 32'(busy), 1);
        if (mid_cfg) begin
            cfg_sel = ~cfg_sel; cfg_div = 16'd9; cfg_burst = 16'd7; cfg_valid = 1'b1;
            chk("cfg_ready_run", 32'(cfg_ready), 0);
            go_cyc(c0 + 1);
            cfg_valid = 1'b0;
        end
        if (stp) begin
            go_cyc(s);
            stop = 1'b1;
            go_cyc(s + 1);
            stop = 1'b0;
        end
        if (r >= 0) begin
            go_cyc(r);
            rst = 1'b1;
            go_cyc(r + 1);
            rst = 1'b0;
            chk("rst_bram_en", 32'(bram_en), 0);
            chk("rst_sample_valid", 32'(sample_valid), 0);
            chk("rst_busy", 32'(busy), 0);
            chk("rst_cfg_ready", 32'(cfg_ready), 1);
            chk("rst_sample_out", 32'(sample_out), 0);
            chk("rst_done", 32'(done), 0);
            m_sel = 0; m_div = 100; m_burst = 0; m_phase = 0;
            go_cyc(r + LAT + 2);
        end else begin
            go_cyc(dc + 1);
            chk("end_busy", 32'(busy), 0);
            chk("end_cfg_ready", 32'(cfg_ready), 1);
            chk("end_done", 32'(done), 0);
        end
        chk("reads_left", rdq.size(), 0);
        chk("samples_left", smq.size(), 0);
        chk("done_left", dnq.size(), 0);
        rdq.delete(); smq.delete(); dnq.delete();
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        chk("reset_cfg_ready", 32'(cfg_ready), 1);
        chk("reset_busy", 32'(busy), 0);
        chk("reset_bram_en", 32'(bram_en), 0);
        chk("reset_sample_valid", 32'(sample_valid), 0);
        chk("reset_done", 32'(done), 0);
        chk("reset_sample_out", 32'(sample_out), 0);
        chk("reset_bram_addr", 32'(bram_addr), 0);

        // sel, div, burst, phase, stop_off, with_cfg, same_cyc, mid_cfg, rst_off
        run_case(2, 1, 1, 0, -1, 1, 0, 0, -1);          // one period, back-to-back reads
        run_case(3, 4, 0, 0, 600 * 4 - 2, 1, 0, 0, -1); // continuous, stop after 600 reads
        run_case(1, 0, 1, 0, -1, 1, 0, 1, -1);          // div 0 acts as 1; config ignored in RUN
        run_case(0, 0, 0, 0, -1, 0, 0, 0, -1);          // reuse latched config
        run_case(1, 1, 2, 0, -1, 1, 1, 0, -1);          // config with start, 512 reads
        run_case(0, 1, 0, 0, 255, 1, 0, 0, -1);         // stop on period-closing tick
        run_case(0, 1, 0, 0, 100, 1, 0, 0, -1);         // stop on ordinary tick
        run_case(0, 3, 0, 0, 0, 1, 0, 0, -1);           // stop in first RUN cycle
        run_case(0, 1, 0, 0, -1, 1, 0, 0, 64);          // reset mid-run at addr 0x40
`ifdef WAVESEQ_PHASE_EN
        run_case(2, 1, 1, 8'h80, -1, 1, 0, 0, -1);      // phase-shifted period
`endif
        for (int k = 0; k < 6; k++) begin
            int sel_r, div_r, burst_r, stop_r, phase_r;
            bit same_r, mid_r;
            sel_r   = int'($urandom_range(0, 3));
            div_r   = int'($urandom_range(0, 3));
            burst_r = int'($urandom_range(0, 2));
            phase_r = int'($urandom_range(0, 255));
            same_r  = 1'($urandom_range(0, 1));
            mid_r   = 1'($urandom_range(0, 1));
            stop_r  = (burst_r == 0 || $urandom_range(0, 1) == 1) ? int'($urandom_range(1, 900)) : -1;
            go_cyc(cyc + int'($urandom_range(0, 3)));
            run_case(sel_r, div_r, burst_r, phase_r, stop_r, 1, same_r, mid_r, -1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Overall time limit so the run always ends.
    initial begin
        #2000000;
        $display("FAIL timeout actual=%0d expected=finished", cyc);
        failures++;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "timeout");
    end

endmodule
